// File: rtl/ysyx_041461_pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a synchronous flush.
//
// SKID=1: two-entry skid buffer. in_ready comes straight from the state flops, so
//         downstream back-pressure never reaches upstream through combinational logic.
// SKID=0: single-entry register. in_ready = ~out_valid | out_ready (pass-through).
//
// Ports:
//   clk       - clock; all state changes happen on the rising edge
//   rst       - asynchronous active-high reset
//   flush     - drops every held beat and any same-cycle incoming beat
//   in_valid  - upstream beat valid
//   in_ready  - stage can accept a beat
//   in_data   - upstream payload
//   out_valid - stage holds a valid beat
//   out_ready - downstream accepts the beat
//   out_data  - payload of the oldest held beat
//   occ       - number of held beats (0..2, at most 1 when SKID=0)
module ysyx_041461_pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  // Encoding equals the beat count, so occ is a direct copy of the state.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_q;
  assign occ       = state_q;

  if (SKID) begin : g_skid
    assign in_ready = (state_q != StFull);
  end else begin : g_pass
    assign in_ready = (state_q == StEmpty) | out_ready;
  end

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (SKID) begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the drain can happen.
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end else begin
      if (in_fire) begin
        state_d = StOne;
        main_d  = in_data;
      end else if (out_fire) begin
        state_d = StEmpty;
      end
    end

    // Flush only kills the valid state; payload registers keep their contents.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_pipe_skid_reg.sv
// Bench for ysyx_041461_pipe_skid_reg: one SKID=1 and one SKID=0 instance side by side,
// DATA_W=8, RESET_VAL=0xC3. The reference model is a FIFO queue per instance with
// capacity 2 or 1.
module tb_ysyx_041461_pipe_skid_reg;

  localparam logic [7:0] RV = 8'hC3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       iv1, ir1, ov1, or1, fl1;
  logic [7:0] d1, od1;
  logic [1:0] occ1;
  logic       iv0, ir0, ov0, or0, fl0;
  logic [7:0] d0, od0;
  logic [1:0] occ0;

  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         n_dlv  = 0;

  always #5 clk = ~clk;

  ysyx_041461_pipe_skid_reg #(.DATA_W(8), .RESET_VAL(RV), .SKID(1'b1)) u_dut_skid (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occ(occ1)
  );

  ysyx_041461_pipe_skid_reg #(.DATA_W(8), .RESET_VAL(RV), .SKID(1'b0)) u_dut_pass (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occ(occ0)
  );

  task automatic idle();
    iv1 = 0; or1 = 0; fl1 = 0; d1 = 8'h00;
    iv0 = 0; or0 = 0; fl0 = 0; d0 = 8'h00;
  endtask

  // Advance one clock and move the queue model according to the handshake rules.
  task automatic step();
    bit if1, of1, if0, of0;
    if1 = iv1 && (q1.size() < 2) && !fl1;
    of1 = (q1.size() > 0) && or1;
    if0 = iv0 && ((q0.size() == 0) || or0) && !fl0;
    of0 = (q0.size() > 0) && or0;
    @(posedge clk);
    if (of1) begin void'(q1.pop_front()); n_dlv++; end
    if (fl1) q1.delete();
    else if (if1) q1.push_back(d1);
    if (of0) begin void'(q0.pop_front()); n_dlv++; end
    if (fl0) q0.delete();
    else if (if0) q0.push_back(d0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL rst_ov1 got %b want 0", ov1); end
    n_cmp++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL rst_occ1 got %0d want 0", occ1); end
    n_cmp++; if (od1 !== RV) begin n_fail++; $display("FAIL rst_od1 got %h want %h", od1, RV); end
    n_cmp++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL rst_ir1 got %b want 1", ir1); end
    n_cmp++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rst_ov0 got %b want 0", ov0); end
    n_cmp++; if (od0 !== RV) begin n_fail++; $display("FAIL rst_od0 got %h want %h", od0, RV); end
    n_cmp++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL rst_ir0 got %b want 1", ir0); end
    @(negedge clk);
    rst = 1'b0;
    q1.delete(); q0.delete();
    #1;
    n_cmp++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL post_rst_ir1 got %b want 1", ir1); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [7:0] seq [3] = '{8'h11, 8'h22, 8'h33};
    idle();
    or1 = 1;
    for (int i = 0; i < 4; i++) begin
      iv1 = (i < 3);
      d1  = (i < 3) ? seq[i] : 8'h00;
      #1;
      n_cmp++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL stream_ir c%0d got %b want 1", i, ir1); end
      if (i > 0) begin
        n_cmp++;
        if (od1 !== seq[i-1] || ov1 !== 1'b1 || occ1 !== 2'd1) begin
          n_fail++;
          $display("FAIL stream_out c%0d got %h/%b/%0d want %h/1/1", i, od1, ov1, occ1, seq[i-1]);
        end
      end
      step();
    end
    #1;
    n_cmp++; if (occ1 !== 2'd0) begin n_fail++; $display("FAIL stream_drain occ got %0d want 0", occ1); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    idle();
    iv1 = 1; d1 = 8'hA0; or1 = 1; #1; step();
    d1 = 8'hA1; #1;
    n_cmp++; if (od1 !== 8'hA0) begin n_fail++; $display("FAIL bp_a0 got %h want a0", od1); end
    step();
    or1 = 0; d1 = 8'hA2; #1; step();
    d1 = 8'hA3; #1;
    n_cmp++;
    if (od1 !== 8'hA1 || occ1 !== 2'd2 || ir1 !== 1'b0 || ov1 !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full got d=%h occ=%0d ir=%b want a1/2/0", od1, occ1, ir1);
    end
    step();
    or1 = 1; #1;
    n_cmp++;
    if (od1 !== 8'hA1 || ir1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain1 got d=%h ir=%b want a1/0", od1, ir1);
    end
    step(); #1;
    n_cmp++;
    if (od1 !== 8'hA2 || ov1 !== 1'b1 || ir1 !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain2 got d=%h ov=%b ir=%b want a2/1/1", od1, ov1, ir1);
    end
    step();
    iv1 = 0; #1;
    n_cmp++;
    if (od1 !== 8'hA3 || ov1 !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain3 got d=%h ov=%b want a3/1", od1, ov1);
    end
    step();
  endtask

  task automatic test_flush();
    idle();
    iv1 = 1; d1 = 8'hB0; #1; step();
    d1 = 8'hB1; #1; step();
    fl1 = 1; d1 = 8'h55; #1;
    n_cmp++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL flush_pre occ got %0d want 2", occ1); end
    step();
    fl1 = 0; iv1 = 0; or1 = 1; #1;
    n_cmp++;
    if (ov1 !== 1'b0 || occ1 !== 2'd0 || ir1 !== 1'b1) begin
      n_fail++; $display("FAIL flush_post got ov=%b occ=%0d ir=%b want 0/0/1", ov1, occ1, ir1);
    end
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      n_cmp++;
      if (ov1 !== 1'b0) begin n_fail++; $display("FAIL flush_leak c%0d got ov=%b d=%h", i, ov1, od1); end
    end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    idle();
    iv0 = 1; d0 = 8'h7E; #1; step();
    iv0 = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (ir0 !== 1'b0 || od0 !== 8'h7E || ov0 !== 1'b1) begin
        n_fail++; $display("FAIL pass_hold c%0d got ir=%b d=%h want 0/7e", i, ir0, od0);
      end
      step();
    end
    or0 = 1; iv0 = 1; d0 = 8'h7F; #1;
    n_cmp++; if (ir0 !== 1'b1) begin n_fail++; $display("FAIL pass_ready got %b want 1", ir0); end
    step();
    iv0 = 0; #1;
    n_cmp++;
    if (od0 !== 8'h7F || ov0 !== 1'b1) begin
      n_fail++; $display("FAIL pass_next got d=%h ov=%b want 7f/1", od0, ov0);
    end
    step();
  endtask

  task automatic test_async_reset();
    idle();
    iv1 = 1; d1 = 8'hD0; #1; step();
    d1 = 8'hD1; #1; step();
    iv1 = 0; #1;
    n_cmp++; if (occ1 !== 2'd2) begin n_fail++; $display("FAIL arst_pre occ got %0d want 2", occ1); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (ov1 !== 1'b0 || occ1 !== 2'd0 || od1 !== RV) begin
      n_fail++; $display("FAIL arst got ov=%b occ=%0d d=%h want 0/0/c3", ov1, occ1, od1);
    end
    q1.delete(); q0.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    iv1 = 1; or1 = 1; d1 = 8'h5A; #1; step();
    iv1 = 0; #1;
    n_cmp++;
    if (od1 !== 8'h5A || ov1 !== 1'b1) begin
      n_fail++; $display("FAIL arst_after got d=%h ov=%b want 5a/1", od1, ov1);
    end
    step();
  endtask

  task automatic test_random();
    logic exp_ir1, exp_ir0;
    idle();
    n_dlv = 0;
    for (int c = 0; c < 10000; c++) begin
      iv1 = $urandom_range(0, 3) != 0; d1 = 8'($urandom);
      or1 = $urandom_range(0, 2) != 0; fl1 = $urandom_range(0, 63) == 0;
      iv0 = $urandom_range(0, 3) != 0; d0 = 8'($urandom);
      or0 = $urandom_range(0, 2) != 0; fl0 = $urandom_range(0, 63) == 0;
      exp_ir1 = q1.size() < 2;
      exp_ir0 = (q0.size() == 0) || or0;
      #1;
      n_cmp++;
      if (ir1 !== exp_ir1 || ov1 !== (q1.size() > 0) || occ1 !== 2'(q1.size())) begin
        n_fail++;
        $display("FAIL rnd_ctl1 c%0d got ir=%b ov=%b occ=%0d want %b/%0d", c, ir1, ov1, occ1,
                 exp_ir1, q1.size());
      end
      if (q1.size() > 0) begin
        n_cmp++;
        if (od1 !== q1[0]) begin n_fail++; $display("FAIL rnd_data1 c%0d got %h want %h", c, od1, q1[0]); end
      end
      n_cmp++;
      if (ir0 !== exp_ir0 || ov0 !== (q0.size() > 0) || occ0 !== 2'(q0.size())) begin
        n_fail++;
        $display("FAIL rnd_ctl0 c%0d got ir=%b ov=%b occ=%0d want %b/%0d", c, ir0, ov0, occ0,
                 exp_ir0, q0.size());
      end
      if (q0.size() > 0) begin
        n_cmp++;
        if (od0 !== q0[0]) begin n_fail++; $display("FAIL rnd_data0 c%0d got %h want %h", c, od0, q0[0]); end
      end
      // Wiggle out_ready mid-cycle: the skid instance's in_ready must not follow it.
      or1 = ~or1; #1;
      n_cmp++;
      if (ir1 !== exp_ir1) begin n_fail++; $display("FAIL rnd_ir_comb c%0d got %b want %b", c, ir1, exp_ir1); end
      or1 = ~or1; #1;
      step();
    end
    n_cmp++;
    if (n_dlv < 1000) begin n_fail++; $display("FAIL rnd_delivered got %0d want >=1000", n_dlv); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_passthrough();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_pipe_skid_reg.md
Name: ysyx_041461_pipe_skid_reg

Overview:
- Parametrised pipeline stage register with a valid/ready handshake and flush.
- Replaces the fixed-field, enable-gated stage registers between IF/ID/EXE/MEM/WB.
- SKID=1 gives a two-entry skid buffer so `in_ready` is a pure register output, which cuts the combinational back-pressure path through the pipeline.
- SKID=0 gives a single-entry register with pass-through ready.
- Each stage packs its fields into one bus of `DATA_W` bits.

Parameters:
- DATA_W, 64, width of the payload bus (≥1).
- RESET_VAL, 0 (DATA_W bits), value loaded into all data registers on reset.
- SKID, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  kill all held beats; highest priority after rst.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  payload of the oldest held beat.
- occ  output  2  number of beats held (0..2; max 1 when SKID=0).

Behaviour:
- Handshakes:
  - in_fire = in_valid & in_ready & ~flush.
  - out_fire = out_valid & out_ready.
- Reset values: out_valid=0, occ=0, main=skid=RESET_VAL, out_data=RESET_VAL.
  - SKID=1: in_ready=1 during and after reset.
  - SKID=0: in_ready=1 during and after reset.
- Storage: `main` register (drives out_data) and `skid` register (SKID=1 only). Data registers load only on the listed events; otherwise they hold.
- SKID=1 state machine. State is EMPTY, ONE or FULL; occ = 0/1/2; out_valid = (state≠EMPTY); in_ready = (state≠FULL), derived from state flops only.
  - EMPTY: in_fire → ONE, main<=in_data.
  - ONE, in_fire & out_fire → ONE, main<=in_data.
  - ONE, in_fire & ~out_fire → FULL, skid<=in_data.
  - ONE, ~in_fire & out_fire → EMPTY.
  - FULL: out_fire → ONE, main<=skid. in_fire cannot occur in FULL.
  - Otherwise the state holds.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - in_fire → main<=in_data, out_valid<=1.
  - out_fire & ~in_fire → out_valid<=0.
- Latency and throughput:
  - One cycle from in_fire to out_valid.
  - Full throughput: one beat per cycle while out_ready=1.
  - SKID=1 absorbs exactly one extra beat after out_ready drops.
- Ordering: beats leave in acceptance order; no beat is duplicated or lost except by flush.
- Flush:
  - Synchronous. Next edge: state→EMPTY, occ=0, out_valid=0.
  - Data registers keep their contents; no reset to RESET_VAL.
  - A same-cycle in_valid beat is discarded even if in_ready=1.
  - A same-cycle out_fire still counts as delivered downstream.
  - SKID=1: in_ready reads 1 on the cycle after flush.
- Reset asserted mid-operation: immediate asynchronous return to reset values; held beats are lost.
- Stability: while out_valid=1 and out_ready=0 (and no flush), out_data and out_valid stay constant.

Test Plan:
- SKID=1, DATA_W=8. Reset, then drive in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data is 0x11,0x22,0x33 one cycle later each; occ stays 1; in_ready stays 1.
- SKID=1 back-pressure. Stream 0xA0..0xA3, drop out_ready after 0xA0 is taken → 0xA1 sits in main and 0xA2 in skid; occ=2; in_ready=0; 0xA3 is held upstream. Raise out_ready → 0xA1,0xA2,0xA3 emerge in order with no gap.
- SKID=1 with occ=2, assert flush one cycle with in_valid=1, in_data=0x55 → next cycle out_valid=0, occ=0, in_ready=1; 0x55 never appears at the output.
- SKID=0, DATA_W=8. Hold out_ready=0 with 0x7E held → in_ready=0 and out_data stays 0x7E. Set out_ready=1 with in_valid=1, in_data=0x7F in the same cycle → in_ready=1 that cycle and 0x7F is on out_data the next cycle.
- Assert rst asynchronously (between edges) with occ=2, RESET_VAL=0xC3 → immediately out_valid=0, occ=0, out_data=0xC3; after rst deasserts, the first accepted beat is delivered normally.
- Randomised out_ready and in_valid for 10k cycles, both SKID values → a scoreboard checks in-order, lossless delivery and that SKID=1 in_ready never depends combinationally on out_ready.
